// File: rtl/dpram_initiator.sv
// Request-side controller for a dual-port RAM serving two clients (A, B).
// Writes share one bus with round-robin arbitration; reads use each client's own port.
module dpram_initiator #(
  parameter int AW     = 2,
  parameter int DW     = 4,
  parameter int RW     = 16,
  parameter int RD_LAT = 1,
  parameter int CW     = 8
) (
  input  logic          clck,
  input  logic          rst,
  input  logic          a_req_valid,
  output logic          a_req_ready,
  input  logic          a_req_we,
  input  logic [AW-1:0] a_req_addr,
  input  logic [DW-1:0] a_req_wdata,
  output logic          a_rsp_valid,
  output logic [RW-1:0] a_rsp_rdata,
  input  logic          b_req_valid,
  output logic          b_req_ready,
  input  logic          b_req_we,
  input  logic [AW-1:0] b_req_addr,
  input  logic [DW-1:0] b_req_wdata,
  output logic          b_rsp_valid,
  output logic [RW-1:0] b_rsp_rdata,
  output logic [1:0]    ram_write,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_a,
  output logic [DW-1:0] ram_data_b,
  output logic          ram_read_a,
  output logic [AW-1:0] ram_address_read_a,
  output logic          ram_read_b,
  output logic [AW-1:0] ram_address_read_b,
  input  logic [RW-1:0] ram_data_out_a,
  input  logic [RW-1:0] ram_data_out_b,
  output logic [CW-1:0] conflict_cnt
);

  localparam logic [2:0] LAST_WAIT = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  // Index 0 is client A, index 1 is client B throughout.
  logic [1:0]    reqValid;
  logic [1:0]    reqWe;
  logic [AW-1:0] reqAddr [2];
  logic [DW-1:0] reqWdata [2];
  logic [RW-1:0] ramRdata [2];

  logic [1:0]    idle;
  logic [1:0]    ready;
  logic [1:0]    accept;
  logic [1:0]    writeAccept;
  logic          contention;

  logic [1:0]    ramRead;
  logic [AW-1:0] ramAddrRead [2];
  logic [DW-1:0] ramData [2];
  logic [1:0]    rspValid;
  logic [RW-1:0] rspRdata [2];

  logic          rrB_q;
  logic [1:0]    ramWrite_q;
  logic [AW-1:0] ramAddress_q;
  logic [CW-1:0] conflictCnt_q;

  assign reqValid    = {b_req_valid, a_req_valid};
  assign reqWe       = {b_req_we, a_req_we};
  assign reqAddr[0]  = a_req_addr;
  assign reqAddr[1]  = b_req_addr;
  assign reqWdata[0] = a_req_wdata;
  assign reqWdata[1] = b_req_wdata;
  assign ramRdata[0] = ram_data_out_a;
  assign ramRdata[1] = ram_data_out_b;

  // Only simultaneous writes from two idle clients contend; the pointer holder wins.
  assign contention  = (&idle) & (&reqValid) & (&reqWe);
  assign ready[0]    = rst & idle[0] & ~(contention & rrB_q);
  assign ready[1]    = rst & idle[1] & ~(contention & ~rrB_q);
  assign accept      = reqValid & ready;
  assign writeAccept = accept & reqWe;

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      rrB_q         <= 1'b0;
      ramWrite_q    <= 2'b00;
      ramAddress_q  <= '0;
      conflictCnt_q <= '0;
    end else begin
      ramWrite_q <= {writeAccept[0], writeAccept[1]};
      if (writeAccept[0]) begin
        ramAddress_q <= reqAddr[0];
      end else if (writeAccept[1]) begin
        ramAddress_q <= reqAddr[1];
      end
      if (contention) begin
        rrB_q <= ~rrB_q;
        if (conflictCnt_q != '1) begin
          conflictCnt_q <= conflictCnt_q + CW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : gClient
    state_e        state_q;
    state_e        state_d;
    logic          isWrite_q;
    logic [2:0]    waitCnt_q;
    logic          lastWait;
    logic          writeIssue;
    logic          ramRead_q;
    logic [AW-1:0] ramAddrRead_q;
    logic [DW-1:0] ramData_q;
    logic          rspValid_q;
    logic [RW-1:0] rspRdata_q;

    assign lastWait   = (state_q == WAIT) && (waitCnt_q == LAST_WAIT);
    assign writeIssue = (state_q == ISSUE) && isWrite_q;

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE:    if (accept[g]) state_d = ISSUE;
        ISSUE:   state_d = isWrite_q ? RESP : WAIT;
        WAIT:    if (lastWait) state_d = RESP;
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Response is launched one edge early so rsp_valid is itself a flop output.
    always_ff @(posedge clck or negedge rst) begin
      if (!rst) begin
        state_q       <= IDLE;
        isWrite_q     <= 1'b0;
        waitCnt_q     <= '0;
        ramRead_q     <= 1'b0;
        ramAddrRead_q <= '0;
        ramData_q     <= '0;
        rspValid_q    <= 1'b0;
        rspRdata_q    <= '0;
      end else begin
        state_q    <= state_d;
        ramRead_q  <= accept[g] & ~reqWe[g];
        rspValid_q <= writeIssue | lastWait;
        if (accept[g]) begin
          isWrite_q <= reqWe[g];
          if (reqWe[g]) begin
            ramData_q <= reqWdata[g];
          end else begin
            ramAddrRead_q <= reqAddr[g];
          end
        end
        if (state_q == WAIT) begin
          waitCnt_q <= waitCnt_q + 3'd1;
        end else begin
          waitCnt_q <= '0;
        end
        if (writeIssue) begin
          rspRdata_q <= '0;
        end else if (lastWait) begin
          rspRdata_q <= ramRdata[g];
        end
      end
    end

    assign idle[g]        = (state_q == IDLE);
    assign ramRead[g]     = ramRead_q;
    assign ramAddrRead[g] = ramAddrRead_q;
    assign ramData[g]     = ramData_q;
    assign rspValid[g]    = rspValid_q;
    assign rspRdata[g]    = rspRdata_q;
  end

  assign a_req_ready        = ready[0];
  assign b_req_ready        = ready[1];
  assign a_rsp_valid        = rspValid[0];
  assign b_rsp_valid        = rspValid[1];
  assign a_rsp_rdata        = rspRdata[0];
  assign b_rsp_rdata        = rspRdata[1];
  assign ram_write          = ramWrite_q;
  assign ram_address        = ramAddress_q;
  assign ram_data_a         = ramData[0];
  assign ram_data_b         = ramData[1];
  assign ram_read_a         = ramRead[0];
  assign ram_read_b         = ramRead[1];
  assign ram_address_read_a = ramAddrRead[0];
  assign ram_address_read_b = ramAddrRead[1];
  assign conflict_cnt       = conflictCnt_q;

endmodule

// File: tb/tb_dpram_initiator.sv
// Directed bench for dpram_initiator with a one-cycle-latency dual-port RAM model.
// Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
module tb_dpram_initiator;

  localparam int AW = 2;
  localparam int DW = 4;
  localparam int RW = 16;
  localparam int CW = 8;

  logic          clck = 1'b0;
  logic          rst  = 1'b0;
  logic          a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [AW-1:0] a_req_addr  = '0;
  logic [DW-1:0] a_req_wdata = '0;
  logic          b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [AW-1:0] b_req_addr  = '0;
  logic [DW-1:0] b_req_wdata = '0;
  logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
  logic [RW-1:0] a_rsp_rdata, b_rsp_rdata;
  logic [1:0]    ram_write;
  logic [AW-1:0] ram_address, ram_address_read_a, ram_address_read_b;
  logic [DW-1:0] ram_data_a, ram_data_b;
  logic          ram_read_a, ram_read_b;
  logic [RW-1:0] ram_data_out_a = '0;
  logic [RW-1:0] ram_data_out_b = '0;
  logic [CW-1:0] conflict_cnt;

  logic [DW-1:0] mem [4] = '{default: '0};

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clck = ~clck;

  dpram_initiator dut (
    .clck(clck), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .ram_write(ram_write), .ram_address(ram_address),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_read_a(ram_read_a), .ram_address_read_a(ram_address_read_a),
    .ram_read_b(ram_read_b), .ram_address_read_b(ram_address_read_b),
    .ram_data_out_a(ram_data_out_a), .ram_data_out_b(ram_data_out_b),
    .conflict_cnt(conflict_cnt)
  );

  // RAM model: registered read, data valid the cycle after the strobe, zero-extended.
  always @(posedge clck) begin
    if (ram_write == 2'b10) mem[ram_address] <= ram_data_a;
    else if (ram_write == 2'b01) mem[ram_address] <= ram_data_b;
    if (ram_read_a) ram_data_out_a <= {12'd0, mem[ram_address_read_a]};
    if (ram_read_b) ram_data_out_b <= {12'd0, mem[ram_address_read_b]};
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic isB, input logic valid, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (!isB) begin
      a_req_valid = valid; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
    end else begin
      b_req_valid = valid; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
    end
  endtask

  task automatic nextCycle();
    @(posedge clck);
    #1;
  endtask

  initial begin
    $display("[TB] reset");
    #2;
    checkOutput("rst_a_ready", 32'(a_req_ready), 0);
    checkOutput("rst_b_ready", 32'(b_req_ready), 0);
    checkOutput("rst_ram_write", 32'(ram_write), 0);
    checkOutput("rst_a_rsp", 32'(a_rsp_valid), 0);
    checkOutput("rst_conflict", 32'(conflict_cnt), 0);
    repeat (2) @(posedge clck);
    #1 rst = 1'b1;
    @(negedge clck);
    checkOutput("rel_a_ready", 32'(a_req_ready), 1);
    checkOutput("rel_b_ready", 32'(b_req_ready), 1);
    checkOutput("rel_conflict", 32'(conflict_cnt), 0);

    $display("[TB] write A addr 0 data 1010");
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 4'b1010);
    @(negedge clck);
    checkOutput("wa_ready", 32'(a_req_ready), 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clck);
    checkOutput("wa_ram_write", 32'(ram_write), 2);
    checkOutput("wa_ram_addr", 32'(ram_address), 0);
    checkOutput("wa_ram_data", 32'(ram_data_a), 'hA);
    checkOutput("wa_ready_busy", 32'(a_req_ready), 0);
    checkOutput("wa_rsp_early", 32'(a_rsp_valid), 0);
    nextCycle();
    @(negedge clck);
    checkOutput("wa_ram_write_off", 32'(ram_write), 0);
    checkOutput("wa_rsp", 32'(a_rsp_valid), 1);
    checkOutput("wa_rsp_rdata", 32'(a_rsp_rdata), 0);
    nextCycle();
    @(negedge clck);
    checkOutput("wa_rsp_end", 32'(a_rsp_valid), 0);
    checkOutput("wa_ready_back", 32'(a_req_ready), 1);

    $display("[TB] write B addr 1 data 1100, then read A addr 1");
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, 4'b1100);
    @(negedge clck);
    checkOutput("wb_ready", 32'(b_req_ready), 1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clck);
    checkOutput("wb_ram_write", 32'(ram_write), 1);
    checkOutput("wb_ram_addr", 32'(ram_address), 1);
    checkOutput("wb_ram_data", 32'(ram_data_b), 'hC);
    nextCycle();
    @(negedge clck);
    checkOutput("wb_rsp", 32'(b_rsp_valid), 1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 4'd0);
    @(negedge clck);
    checkOutput("ra_ready", 32'(a_req_ready), 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clck);
    checkOutput("ra_strobe", 32'(ram_read_a), 1);
    checkOutput("ra_addr", 32'(ram_address_read_a), 1);
    checkOutput("ra_no_write", 32'(ram_write), 0);
    nextCycle();
    @(negedge clck);
    checkOutput("ra_strobe_off", 32'(ram_read_a), 0);
    checkOutput("ra_rsp_wait", 32'(a_rsp_valid), 0);
    nextCycle();
    @(negedge clck);
    checkOutput("ra_rsp", 32'(a_rsp_valid), 1);
    checkOutput("ra_rdata", 32'(a_rsp_rdata), 'h000C);
    nextCycle();
    @(negedge clck);
    checkOutput("ra_rsp_end", 32'(a_rsp_valid), 0);
    checkOutput("ra_ready_back", 32'(a_req_ready), 1);

    $display("[TB] simultaneous writes, A favoured");
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 4'b0110);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 4'b1111);
    @(negedge clck);
    checkOutput("c1_a_ready", 32'(a_req_ready), 1);
    checkOutput("c1_b_ready", 32'(b_req_ready), 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clck);
    checkOutput("c1_b_ready2", 32'(b_req_ready), 1);
    checkOutput("c1_ram_write_a", 32'(ram_write), 2);
    checkOutput("c1_ram_addr_a", 32'(ram_address), 2);
    checkOutput("c1_ram_data_a", 32'(ram_data_a), 'h6);
    checkOutput("c1_conflict", 32'(conflict_cnt), 1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clck);
    checkOutput("c1_ram_write_b", 32'(ram_write), 1);
    checkOutput("c1_ram_addr_b", 32'(ram_address), 3);
    checkOutput("c1_ram_data_b", 32'(ram_data_b), 'hF);
    checkOutput("c1_a_rsp", 32'(a_rsp_valid), 1);
    nextCycle();
    @(negedge clck);
    checkOutput("c1_b_rsp", 32'(b_rsp_valid), 1);
    nextCycle();

    $display("[TB] second contention, B favoured");
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 4'b0011);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, 4'b0101);
    @(negedge clck);
    checkOutput("c2_a_ready", 32'(a_req_ready), 0);
    checkOutput("c2_b_ready", 32'(b_req_ready), 1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clck);
    checkOutput("c2_a_ready2", 32'(a_req_ready), 1);
    checkOutput("c2_ram_write_b", 32'(ram_write), 1);
    checkOutput("c2_conflict", 32'(conflict_cnt), 2);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clck);
    checkOutput("c2_ram_write_a", 32'(ram_write), 2);
    repeat (3) nextCycle();

    $display("[TB] parallel reads addr 3");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 4'd0);
    @(negedge clck);
    checkOutput("pr_a_ready", 32'(a_req_ready), 1);
    checkOutput("pr_b_ready", 32'(b_req_ready), 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clck);
    checkOutput("pr_strobe_a", 32'(ram_read_a), 1);
    checkOutput("pr_strobe_b", 32'(ram_read_b), 1);
    checkOutput("pr_addr_b", 32'(ram_address_read_b), 3);
    checkOutput("pr_conflict", 32'(conflict_cnt), 2);
    nextCycle();
    nextCycle();
    @(negedge clck);
    checkOutput("pr_a_rsp", 32'(a_rsp_valid), 1);
    checkOutput("pr_b_rsp", 32'(b_rsp_valid), 1);
    checkOutput("pr_a_rdata", 32'(a_rsp_rdata), 'h000F);
    checkOutput("pr_b_rdata", 32'(b_rsp_rdata), 'h000F);
    repeat (2) nextCycle();

    $display("[TB] third contention moves pointer to B");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 4'b1001);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd2, 4'b0001);
    @(negedge clck);
    checkOutput("c3_a_ready", 32'(a_req_ready), 1);
    checkOutput("c3_b_ready", 32'(b_req_ready), 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clck);
    checkOutput("c3_conflict", 32'(conflict_cnt), 3);
    repeat (3) nextCycle();

    $display("[TB] reset during read wait");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    nextCycle();
    #2 rst = 1'b0;
    #1;
    checkOutput("mr_a_ready", 32'(a_req_ready), 0);
    checkOutput("mr_b_ready", 32'(b_req_ready), 0);
    checkOutput("mr_a_rsp", 32'(a_rsp_valid), 0);
    checkOutput("mr_conflict", 32'(conflict_cnt), 0);
    checkOutput("mr_ram_addr", 32'(ram_address), 0);
    checkOutput("mr_read_addr", 32'(ram_address_read_a), 0);
    checkOutput("mr_ram_data_a", 32'(ram_data_a), 0);
    @(posedge clck);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clck);
      checkOutput("mr_no_rsp", 32'(a_rsp_valid), 0);
      checkOutput("mr_ready_back", 32'(a_req_ready), 1);
      nextCycle();
    end

    $display("[TB] contention after reset favours A");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 4'b0111);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd2, 4'b1000);
    @(negedge clck);
    checkOutput("c4_a_ready", 32'(a_req_ready), 1);
    checkOutput("c4_b_ready", 32'(b_req_ready), 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clck);
    checkOutput("c4_ram_write_a", 32'(ram_write), 2);
    checkOutput("c4_conflict", 32'(conflict_cnt), 1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clck);
    checkOutput("c4_ram_write_b", 32'(ram_write), 1);
    repeat (3) nextCycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dpram_initiator.md
Name: dpram_initiator

Overview:
Request-side controller that drives the dual-port RAM block (`arch`) on behalf of two independent clients, A and B. Each client issues single-word read/write requests over a valid/ready handshake. The block serializes writes onto the RAM's shared write bus with round-robin arbitration and routes reads to each client's dedicated read port. It captures read data and returns one response per request.

Parameters:
AW, 2, address width (RAM depth 2**AW)
DW, 4, write data width (ram_data_a / ram_data_b)
RW, 16, read data width (ram_data_out_a / ram_data_out_b)
RD_LAT, 1, RAM read latency in cycles from the read-strobe cycle to valid data_out (1..4)
CW, 8, width of the write-conflict counter

Ports:
clck  in  1  single system clock, rising edge
rst  in  1  reset, asynchronous, active-low
a_req_valid  in  1  client A request valid
a_req_ready  out  1  client A may issue a request
a_req_we  in  1  1 = write, 0 = read
a_req_addr  in  AW  client A address
a_req_wdata  in  DW  client A write data
a_rsp_valid  out  1  one-cycle response pulse for client A
a_rsp_rdata  out  RW  read data for client A (0 for write acks)
b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata  same as the A ports, for client B
ram_write  out  2  write select: 2'b10 = port A, 2'b01 = port B, 2'b00 = idle
ram_address  out  AW  shared write address
ram_data_a  out  DW  port A write data
ram_data_b  out  DW  port B write data
ram_read_a  out  1  port A read strobe
ram_address_read_a  out  AW  port A read address
ram_read_b  out  1  port B read strobe
ram_address_read_b  out  AW  port B read address
ram_data_out_a  in  RW  port A read data from the RAM
ram_data_out_b  in  RW  port B read data from the RAM
conflict_cnt  out  CW  saturating count of write-contention cycles

Behaviour:
- Reset (rst low): all outputs are 0 immediately, including both ready signals. In-flight requests are dropped and no response is issued for them. The round-robin pointer resets to favour A.
- On reset release, both ready signals are 1 in the first clock cycle.
- All RAM-side outputs and rsp_* outputs are registered. req_ready is combinational from state and the arbitration result.
- Each client has its own FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Each client has at most one request outstanding.
- req_ready is 1 only in IDLE, and is further masked by write arbitration. A request is accepted in cycle T when valid && ready.
- Requester rule: once valid is asserted, valid, we, addr and wdata are held until accepted. The block does not check this rule.
- Read accepted at T:
  - ISSUE in T+1: ram_read_x = 1, ram_address_read_x = addr, for exactly one cycle.
  - WAIT lasts RD_LAT cycles. ram_data_out_x is sampled at the rising edge that ends cycle T+1+RD_LAT.
  - RESP: rsp_valid = 1 and rsp_rdata = the sampled data in cycle T+2+RD_LAT.
  - ready returns to 1 the following cycle.
- Write accepted at T:
  - ISSUE in T+1: ram_write = the client's one-hot bit, ram_address = addr, ram_data_x = wdata, for exactly one cycle.
  - WAIT is skipped. RESP in T+2 with rsp_rdata = 0.
- Outside ISSUE cycles: ram_write = 2'b00, ram_read_x = 0, and address/data outputs hold their last value.
- Write arbitration applies when both clients are in IDLE with valid && we in the same cycle:
  - The client holding the pointer gets ready = 1 and the other gets ready = 0.
  - The pointer then flips to the loser.
  - The loser stays pending and is accepted the next cycle, because the write bus is busy for only one cycle.
- ram_write == 2'b11 never occurs.
- Read requests never contend with each other and are never blocked by a write from the other client.
- Read and write to the same address from different clients in overlapping cycles: no ordering or forwarding. The result is whatever the RAM returns.
- conflict_cnt increments by 1 in each contention cycle and saturates at 2**CW-1. Reset clears it.

Test Plan:
- Reset then idle: rst low for 2 cycles -> all outputs 0. After release, a_req_ready = b_req_ready = 1 and conflict_cnt = 0.
- Write A addr 00 data 1010, accepted at T -> ram_write = 10, ram_address = 00, ram_data_a = 1010 in T+1 only. a_rsp_valid in T+2 with rdata 0.
- Write B addr 01 data 1100 -> ram_write = 01 in T+1. Then read A addr 01 with the RAM model at RD_LAT = 1 -> ram_read_a = 1 in T'+1. a_rsp_valid with rdata = 16'h000C (the model's output) in T'+3.
- Simultaneous writes: A addr 10 data 0110 and B addr 11 data 1111 in the same cycle, first after reset -> A granted at T and B at T+1. ram_write = 10 then 01, conflict_cnt = 1. The next contention grants B first.
- Parallel reads: A and B read addr 11 in the same cycle -> both strobes in T+1 and both rsp_valid in T+3. Neither ready is masked and conflict_cnt is unchanged.
- Reset mid-operation: assert rst during a read's WAIT cycle -> outputs 0 asynchronously and no rsp_valid pulse after release. The pointer favours A again.
